// File: rtl/mux4_round_robin_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux4_round_robin_arbiter_pkg
// Brief    : Shared constants, state encoding and helpers for the 4-way
//            round-robin mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux4_round_robin_arbiter_pkg;

   localparam int c_num_req = 4;
   localparam int c_sel_w   = 2;
   localparam int c_cnt_w   = 5;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } arb_state_e;

   function automatic logic [c_num_req-1:0] onehot(input logic [c_sel_w-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_round_robin_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin search: first eligible requester
//            starting at pointer and wrapping 3 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
   import mux4_round_robin_arbiter_pkg::*;
(
   input  logic [c_num_req-1:0] requests,
   input  logic [c_sel_w-1:0]   pointer,
   input  logic [c_num_req-1:0] exclude,
   output logic                 found,
   output logic [c_sel_w-1:0]   index
);

   logic [c_num_req-1:0] w_eligible;
   logic [c_sel_w-1:0]   w_idx;

   assign w_eligible = requests & ~exclude;

   // Walk from the farthest offset back to the pointer so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      index = pointer;
      w_idx = pointer;
      for (int k = c_num_req - 1; k >= 0; k--) begin
         w_idx = pointer + c_sel_w'(k);
         if (w_eligible[w_idx]) begin
            found = 1'b1;
            index = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux4_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_round_robin_arbiter
// Brief    : Round-robin owner of the shared 4-input result mux; registered
//            one-hot grants and mux select. Define MUX4_ARB_HOLD_LIMIT_EN to
//            enable forced rotation after HOLD_LIMIT owner cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_round_robin_arbiter
   import mux4_round_robin_arbiter_pkg::*;
#(
   parameter int HOLD_LIMIT = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [c_num_req-1:0] requests,
   output logic [c_num_req-1:0] grants,
   output logic [c_sel_w-1:0]   addresses,
   output logic                 busValid,
   output logic                 grantChanged
);

   arb_state_e           r_state,         w_state_nxt;
   logic [c_sel_w-1:0]   r_owner,         w_owner_nxt;
   logic [c_sel_w-1:0]   r_pointer,       w_pointer_nxt;
   logic [c_num_req-1:0] r_grants,        w_grants_nxt;
   logic [c_sel_w-1:0]   r_addresses,     w_addresses_nxt;
   logic                 r_bus_valid,     w_bus_valid_nxt;
   logic                 r_grant_changed, w_grant_changed_nxt;

   logic [c_sel_w-1:0]   w_pick_ptr;
   logic [c_num_req-1:0] w_pick_excl;
   logic                 w_found;
   logic [c_sel_w-1:0]   w_pick_idx;
   logic                 w_force;
   logic                 w_hold_clr;

   // While granted, search from owner+1 excluding the owner: this serves both
   // the release pick (owner not requesting) and the forced-rotation pick.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_pick_ptr  = r_pointer;
         w_pick_excl = '0;
      end else begin
         w_pick_ptr  = r_owner + 2'd1;
         w_pick_excl = onehot(r_owner);
      end
   end

   rr_priority_picker u_picker (
      .requests (requests),
      .pointer  (w_pick_ptr),
      .exclude  (w_pick_excl),
      .found    (w_found),
      .index    (w_pick_idx)
   );

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_LIMIT - 1);
   localparam logic [c_cnt_w-1:0] c_hold_max  = '1;

   logic [c_cnt_w-1:0] r_hold_count;

   assign w_force = (r_hold_count == c_hold_last) && w_found;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_count <= '0;
      end else if (w_hold_clr) begin
         r_hold_count <= '0;
      end else if (r_hold_count != c_hold_max) begin
         r_hold_count <= r_hold_count + 1'b1;
      end
   end
`else
   logic w_unused_hold;

   assign w_force       = 1'b0;
   assign w_unused_hold = (HOLD_LIMIT != 0) ^ w_hold_clr;
`endif

   always_comb begin
      w_state_nxt         = r_state;
      w_owner_nxt         = r_owner;
      w_pointer_nxt       = r_pointer;
      w_grants_nxt        = r_grants;
      w_addresses_nxt     = r_addresses;
      w_bus_valid_nxt     = r_bus_valid;
      w_grant_changed_nxt = 1'b0;
      w_hold_clr          = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt         = ST_GRANTED;
               w_owner_nxt         = w_pick_idx;
               w_grants_nxt        = onehot(w_pick_idx);
               w_addresses_nxt     = w_pick_idx;
               w_bus_valid_nxt     = 1'b1;
               w_grant_changed_nxt = 1'b1;
            end
         end
         ST_GRANTED: begin
            if (requests[r_owner] && !w_force) begin
               w_hold_clr = 1'b0;
            end else begin
               w_pointer_nxt = r_owner + 2'd1;
               if (w_found) begin
                  w_owner_nxt         = w_pick_idx;
                  w_grants_nxt        = onehot(w_pick_idx);
                  w_addresses_nxt     = w_pick_idx;
                  w_grant_changed_nxt = 1'b1;
               end else begin
                  // Select is left alone so the mux input stays stable while idle.
                  w_state_nxt     = ST_IDLE;
                  w_grants_nxt    = '0;
                  w_bus_valid_nxt = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_owner         <= '0;
         r_pointer       <= '0;
         r_grants        <= '0;
         r_addresses     <= '0;
         r_bus_valid     <= 1'b0;
         r_grant_changed <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_owner         <= w_owner_nxt;
         r_pointer       <= w_pointer_nxt;
         r_grants        <= w_grants_nxt;
         r_addresses     <= w_addresses_nxt;
         r_bus_valid     <= w_bus_valid_nxt;
         r_grant_changed <= w_grant_changed_nxt;
      end
   end

   assign grants       = r_grants;
   assign addresses    = r_addresses;
   assign busValid     = r_bus_valid;
   assign grantChanged = r_grant_changed;

endmodule
`default_nettype wire

// File: tb/tb_mux4_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_round_robin_arbiter
// Brief    : Scoreboard bench for mux4_round_robin_arbiter with a behavioural
//            round-robin reference model; directed plan then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_round_robin_arbiter;

   localparam int HL = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] requests = 4'b0000;
   logic [3:0] grants;
   logic [1:0] addresses;
   logic       busValid;
   logic       grantChanged;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] a;
      logic       v;
      logic       gc;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   checks = 0;
   int   passes = 0;
   int   cycle  = 0;

   int   m_owner   = 0;
   int   m_ptr     = 0;
   int   m_hold    = 0;
   int   m_addr    = 0;
   bit   m_granted = 1'b0;
   bit   m_gc      = 1'b0;

   mux4_round_robin_arbiter #(.HOLD_LIMIT(HL)) dut (
      .clk          (clk),
      .reset        (reset),
      .requests     (requests),
      .grants       (grants),
      .addresses    (addresses),
      .busValid     (busValid),
      .grantChanged (grantChanged)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] req, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (start + k) % 4;
         if (req[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] req, input bit rs);
      int p;
      bit forced;
      m_gc = 1'b0;
      if (rs) begin
         m_granted = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0; m_addr = 0;
      end else if (!m_granted) begin
         p = pick(req, m_ptr, -1);
         if (p >= 0) begin
            m_granted = 1'b1; m_owner = p; m_addr = p; m_gc = 1'b1; m_hold = 0;
         end
      end else begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         forced = (m_hold == HL - 1) && (pick(req, (m_owner + 1) % 4, m_owner) >= 0);
`else
         forced = 1'b0;
`endif
         if (req[m_owner] && !forced) begin
            m_hold = (m_hold < 31) ? m_hold + 1 : 31;
         end else begin
            m_ptr = (m_owner + 1) % 4;
            p = pick(req, m_ptr, m_owner);
            m_hold = 0;
            if (p >= 0) begin
               m_owner = p; m_addr = p; m_gc = 1'b1;
            end else begin
               m_granted = 1'b0;
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.g  = m_granted ? 4'(1 << m_owner) : 4'b0000;
      e.a  = 2'(m_addr);
      e.v  = m_granted;
      e.gc = m_gc;
      return e;
   endfunction

   // Apply one cycle of stimulus and queue the response expected after the next edge.
   task automatic cyc(input logic [3:0] r, input bit rs);
      bit rise;
      @(negedge clk);
      rise     = rs && !reset;
      reset    = rs;
      requests = r;
      model_step(r, rs);
      q.push_back(model_out());
      if (rise) begin
         #1;
         checks++;
         if (grants == 4'b0000 && addresses == 2'd0 && !busValid && !grantChanged)
            passes++;
         else
            $display("FAIL async_reset: got grants=%b addr=%0d valid=%b changed=%b, expected 0000/0/0/0",
                     grants, addresses, busValid, grantChanged);
      end
   endtask

   task automatic rep(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) cyc(r, 1'b0);
   endtask

   always @(posedge clk) begin
      cycle <= cycle + 1;
      #1;
      if (q.size() != 0) begin
         e_mon = q.pop_front();
         checks++;
         if (grants == e_mon.g && addresses == e_mon.a && busValid == e_mon.v &&
             grantChanged == e_mon.gc)
            passes++;
         else
            $display("FAIL scoreboard cycle %0d: got grants=%b addr=%0d valid=%b changed=%b, expected grants=%b addr=%0d valid=%b changed=%b",
                     cycle, grants, addresses, busValid, grantChanged,
                     e_mon.g, e_mon.a, e_mon.v, e_mon.gc);
      end
   end

   initial begin
      logic [3:0] r;
      bit         rs;
      int         waited;
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b0);
      // fair rotation through the 3 -> 0 wrap
      cyc(4'b1111, 1'b0);
      cyc(4'b1110, 1'b0);
      cyc(4'b1100, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      rep(4'b0000, 2);
      // release to idle keeps the select
      rep(4'b0010, 2);
      rep(4'b0000, 2);
      // priority after release
      cyc(4'b0010, 1'b0);
      cyc(4'b0111, 1'b0);
      cyc(4'b0101, 1'b0);
      rep(4'b0000, 2);
      // reset mid-grant, then regrant
      rep(4'b0100, 3);
      cyc(4'b0100, 1'b1);
      cyc(4'b0100, 1'b1);
      rep(4'b0100, 3);
      rep(4'b0000, 2);
      // long holds: contended and uncontended
      rep(4'b0011, 50);
      rep(4'b0000, 2);
      rep(4'b0001, 40);
      rep(4'b0000, 2);
      // random traffic
      r = 4'b0000;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 149) == 0);
         cyc(r, rs);
      end
      cyc(4'b0000, 1'b0);
      waited = 0;
      while (q.size() != 0 && waited < 10) begin
         @(posedge clk);
         #2;
         waited++;
      end
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL drain: got %0d pending, expected 0", q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
